wf68k30l_bus_arbiter: RTL and testbench
=======================================

// Module: wf68k30l_bus_arbiter
//
// PURPOSE
// Arbitrates the single bus interface controller between four requesters:
// exception handler (EXH), data write (WR), data read (RD) and opcode
// prefetch (OPD). It sits between the fetch/execute control and the bus
// interface. It serialises transfers and holds the bus across read-modify-
// write cycles (TAS/CAS/CAS2). A starvation counter guarantees opcode-fetch
// progress under back-to-back operand traffic.
//
// PARAMETERS
// STARVE_MAX  4  consecutive data grants (RD/WR) with OPD pending before OPD is forced; range 1..15
//
// PORTS
// CLK        in   1  clock; all state changes on rising edge
// RESET_n    in   1  asynchronous, active-low reset
// EXH_REQ    in   1  exception-handler bus request (stack/vector access)
// WR_REQ     in   1  operand write request
// RD_REQ     in   1  operand read request
// OPD_REQ    in   1  opcode/extension-word prefetch request
// RMW_LOCK   in   1  sampled with RD grant; holds bus for following WR (locked cycle)
// BUS_ACK    in   1  bus controller accepted current request (1-cycle pulse)
// BUS_DONE   in   1  current transfer complete (1-cycle pulse)
// BUS_ERR    in   1  bus error on current transfer; valid only with BUS_DONE
// BUS_REQ    out  1  request to bus controller
// BUS_SEL    out  2  granted source: 0=OPD 1=RD 2=WR 3=EXH
// BUS_LOCK   out  1  locked RMW cycle in progress (drives RMC)
// GNT        out  4  one-hot grant {EXH,WR,RD,OPD}; stable from grant until DONE
// DONE       out  4  one-hot completion pulse {EXH,WR,RD,OPD}
// ERR        out  1  pulse with DONE when BUS_ERR sampled
//
// BEHAVIOUR
// Reset: state=IDLE; BUS_REQ=0, BUS_SEL=0, BUS_LOCK=0, GNT=0, DONE=0, ERR=0, starve_cnt=0.
// States: IDLE, ARB_REQ (BUS_REQ=1, waiting BUS_ACK), XFER (waiting BUS_DONE), LOCKED.
// IDLE: if any request is pending, select winner, register GNT/BUS_SEL, go to ARB_REQ.
//   The grant is registered, so BUS_REQ rises 1 cycle after the request.
// Priority: EXH > forced OPD (starve_cnt==STARVE_MAX && OPD_REQ) > WR > RD > OPD.
// ARB_REQ: hold BUS_REQ, BUS_SEL, GNT stable. On BUS_ACK, drop BUS_REQ and go to XFER.
//   Requester deassert before ACK is ignored; the transfer completes.
// XFER: on BUS_DONE, pulse DONE[src] and ERR=BUS_ERR for one cycle, clear GNT.
//   Locked RD without error: go to LOCKED. Otherwise go to IDLE.
//   No back-to-back grant on the DONE cycle; minimum 1 idle cycle between transfers.
// BUS_DONE while not in XFER is ignored. BUS_ACK while not in ARB_REQ is ignored.
// RMW: RMW_LOCK sampled on the RD grant cycle. Locked RD sets BUS_LOCK at the RD grant.
//   LOCKED: only WR_REQ may win; EXH, RD and OPD are blocked.
//   The locked WR is granted like a normal WR. BUS_LOCK clears on that WR's DONE.
//   BUS_ERR on the locked RD or locked WR clears BUS_LOCK at DONE, then go to IDLE.
// EXH_REQ in LOCKED: blocked until the lock releases.
// Starvation counter: increments (saturating at STARVE_MAX) on each RD/WR grant while OPD_REQ=1.
//   Cleared on an OPD grant or when OPD_REQ=0 in IDLE.
//   Not incremented for EXH grants or for the locked WR.
// Simultaneous: a request arriving the same cycle as DONE is evaluated in the next IDLE cycle.
// Reset mid-transfer: returns to IDLE immediately; all outputs take reset values.
//   No DONE is issued for the aborted transfer.
//
// TESTING
// 1 Reset: RESET_n=0 during XFER -> GNT=0, BUS_REQ=0, BUS_LOCK=0 next edge; no DONE pulse.
// 2 Priority: EXH,WR,RD,OPD asserted together, ACK/DONE 2 cycles each ->
//   grant order EXH, WR, RD, OPD; one DONE per transfer.
// 3 Starvation: STARVE_MAX=4, RD_REQ and OPD_REQ held high ->
//   grants RD,RD,RD,RD,OPD,RD..., starve_cnt returns to 0 after the OPD grant.
// 4 RMW: RD+RMW_LOCK, EXH_REQ during LOCKED, then WR_REQ ->
//   BUS_LOCK=1 from RD grant; WR granted before EXH; BUS_LOCK=0 after WR DONE; then EXH granted.
// 5 Error: BUS_DONE+BUS_ERR on locked RD -> DONE=4'b0010 and ERR=1 for 1 cycle;
//   BUS_LOCK=0; state IDLE; pending WR then arbitrated normally.
// 6 Spurious: BUS_DONE pulse in IDLE and BUS_ACK in XFER -> no state change; no DONE; no ERR.

Source files
------------

// File: rtl/wf68k30l_bus_arbiter.sv
// Bus arbiter for the single bus interface controller: serialises EXH/WR/RD/OPD
// requests, holds the bus across locked read-modify-write pairs and bounds opcode-fetch starvation.
module wf68k30l_bus_arbiter #(
   parameter int STARVE_MAX = 4
) (
   input  logic       CLK,
   input  logic       RESET_n,
   input  logic       EXH_REQ,
   input  logic       WR_REQ,
   input  logic       RD_REQ,
   input  logic       OPD_REQ,
   input  logic       RMW_LOCK,
   input  logic       BUS_ACK,
   input  logic       BUS_DONE,
   input  logic       BUS_ERR,
   output logic       BUS_REQ,
   output logic [1:0] BUS_SEL,
   output logic       BUS_LOCK,
   output logic [3:0] GNT,
   output logic [3:0] DONE,
   output logic       ERR
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARB_REQ = 2'd1,
      ST_XFER    = 2'd2,
      ST_LOCKED  = 2'd3
   } state_t;

   localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);
   localparam logic [1:0] SEL_OPD = 2'd0;
   localparam logic [1:0] SEL_RD  = 2'd1;
   localparam logic [1:0] SEL_WR  = 2'd2;
   localparam logic [1:0] SEL_EXH = 2'd3;
   localparam logic [3:0] GNT_OPD = 4'b0001;
   localparam logic [3:0] GNT_RD  = 4'b0010;
   localparam logic [3:0] GNT_WR  = 4'b0100;
   localparam logic [3:0] GNT_EXH = 4'b1000;

   state_t     state_r, state_s;
   logic       bus_req_r, bus_req_s;
   logic [1:0] bus_sel_r, bus_sel_s;
   logic       bus_lock_r, bus_lock_s;
   logic [3:0] gnt_r, gnt_s;
   logic [3:0] done_r, done_s;
   logic       err_r, err_s;
   logic [3:0] starve_cnt_r, starve_cnt_s;
   logic       lock_rd_r, lock_rd_s;

   // Saturating increment of the opcode-fetch starvation counter.
   function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
      if (cnt == CNT_MAX) begin
         return cnt;
      end else begin
         return cnt + 4'd1;
      end
   endfunction

   // Next-state and next-output logic for the arbitration FSM.
   always_comb begin
      state_s      = state_r;
      bus_req_s    = bus_req_r;
      bus_sel_s    = bus_sel_r;
      bus_lock_s   = bus_lock_r;
      gnt_s        = gnt_r;
      done_s       = 4'b0000;
      err_s        = 1'b0;
      starve_cnt_s = starve_cnt_r;
      lock_rd_s    = lock_rd_r;
      case (state_r)
         ST_IDLE: begin
            if (!OPD_REQ) begin
               starve_cnt_s = 4'd0;
            end else begin
               starve_cnt_s = starve_cnt_r;
            end
            lock_rd_s = 1'b0;
            if (EXH_REQ) begin
               gnt_s     = GNT_EXH;
               bus_sel_s = SEL_EXH;
               bus_req_s = 1'b1;
               state_s   = ST_ARB_REQ;
            end else if (OPD_REQ && (starve_cnt_r == CNT_MAX)) begin
               gnt_s        = GNT_OPD;
               bus_sel_s    = SEL_OPD;
               bus_req_s    = 1'b1;
               starve_cnt_s = 4'd0;
               state_s      = ST_ARB_REQ;
            end else if (WR_REQ) begin
               gnt_s     = GNT_WR;
               bus_sel_s = SEL_WR;
               bus_req_s = 1'b1;
               state_s   = ST_ARB_REQ;
               if (OPD_REQ) begin
                  starve_cnt_s = sat_inc(starve_cnt_r);
               end else begin
                  starve_cnt_s = 4'd0;
               end
            end else if (RD_REQ) begin
               gnt_s      = GNT_RD;
               bus_sel_s  = SEL_RD;
               bus_req_s  = 1'b1;
               bus_lock_s = RMW_LOCK;
               lock_rd_s  = RMW_LOCK;
               state_s    = ST_ARB_REQ;
               if (OPD_REQ) begin
                  starve_cnt_s = sat_inc(starve_cnt_r);
               end else begin
                  starve_cnt_s = 4'd0;
               end
            end else if (OPD_REQ) begin
               gnt_s        = GNT_OPD;
               bus_sel_s    = SEL_OPD;
               bus_req_s    = 1'b1;
               starve_cnt_s = 4'd0;
               state_s      = ST_ARB_REQ;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ARB_REQ: begin
            if (BUS_ACK) begin
               bus_req_s = 1'b0;
               state_s   = ST_XFER;
            end else begin
               state_s = ST_ARB_REQ;
            end
         end
         ST_XFER: begin
            if (BUS_DONE) begin
               done_s    = gnt_r;
               err_s     = BUS_ERR;
               gnt_s     = 4'b0000;
               lock_rd_s = 1'b0;
               // An error on either half of a locked pair abandons the lock.
               if (lock_rd_r && !BUS_ERR) begin
                  state_s = ST_LOCKED;
               end else begin
                  bus_lock_s = 1'b0;
                  state_s    = ST_IDLE;
               end
            end else begin
               state_s = ST_XFER;
            end
         end
         ST_LOCKED: begin
            // Only the write half of the RMW pair may use the bus here.
            if (WR_REQ) begin
               gnt_s     = GNT_WR;
               bus_sel_s = SEL_WR;
               bus_req_s = 1'b1;
               state_s   = ST_ARB_REQ;
            end else begin
               state_s = ST_LOCKED;
            end
         end
         default: begin
            state_s    = ST_IDLE;
            bus_req_s  = 1'b0;
            bus_lock_s = 1'b0;
            gnt_s      = 4'b0000;
            lock_rd_s  = 1'b0;
         end
      endcase
   end

   // State and registered-output update.
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         state_r      <= ST_IDLE;
         bus_req_r    <= 1'b0;
         bus_sel_r    <= 2'd0;
         bus_lock_r   <= 1'b0;
         gnt_r        <= 4'b0000;
         done_r       <= 4'b0000;
         err_r        <= 1'b0;
         starve_cnt_r <= 4'd0;
         lock_rd_r    <= 1'b0;
      end else begin
         state_r      <= state_s;
         bus_req_r    <= bus_req_s;
         bus_sel_r    <= bus_sel_s;
         bus_lock_r   <= bus_lock_s;
         gnt_r        <= gnt_s;
         done_r       <= done_s;
         err_r        <= err_s;
         starve_cnt_r <= starve_cnt_s;
         lock_rd_r    <= lock_rd_s;
      end
   end

   assign BUS_REQ  = bus_req_r;
   assign BUS_SEL  = bus_sel_r;
   assign BUS_LOCK = bus_lock_r;
   assign GNT      = gnt_r;
   assign DONE     = done_r;
   assign ERR      = err_r;

endmodule

// File: tb/tb_wf68k30l_bus_arbiter.sv
// Directed, table-driven bench for wf68k30l_bus_arbiter: priority, spurious
// handshakes, reset abort, starvation forcing, locked RMW and error release.
module tb_wf68k30l_bus_arbiter;

   logic       CLK = 1'b0;
   logic       RESET_n = 1'b0;
   logic       EXH_REQ, WR_REQ, RD_REQ, OPD_REQ, RMW_LOCK, BUS_ACK, BUS_DONE, BUS_ERR;
   logic       BUS_REQ, BUS_LOCK, ERR;
   logic [1:0] BUS_SEL;
   logic [3:0] GNT, DONE;
   logic [12:0] obs;

   int checks = 0;
   int errors = 0;

   localparam logic [7:0] I_EXH  = 8'b1000_0000;
   localparam logic [7:0] I_WR   = 8'b0100_0000;
   localparam logic [7:0] I_RD   = 8'b0010_0000;
   localparam logic [7:0] I_OPD  = 8'b0001_0000;
   localparam logic [7:0] I_RMW  = 8'b0000_1000;
   localparam logic [7:0] I_ACK  = 8'b0000_0100;
   localparam logic [7:0] I_DONE = 8'b0000_0010;
   localparam logic [7:0] I_ERR  = 8'b0000_0001;
   localparam logic [12:0] FULL   = 13'b1_11_1_1111_1111_1;
   localparam logic [12:0] NO_SEL = 13'b1_00_1_1111_1111_1;

   typedef struct {
      logic [7:0]  stim;
      logic [12:0] exp;
   } vec_t;
   vec_t vecs [27];

   wf68k30l_bus_arbiter #(.STARVE_MAX(4)) dut (
      .CLK(CLK), .RESET_n(RESET_n),
      .EXH_REQ(EXH_REQ), .WR_REQ(WR_REQ), .RD_REQ(RD_REQ), .OPD_REQ(OPD_REQ),
      .RMW_LOCK(RMW_LOCK), .BUS_ACK(BUS_ACK), .BUS_DONE(BUS_DONE), .BUS_ERR(BUS_ERR),
      .BUS_REQ(BUS_REQ), .BUS_SEL(BUS_SEL), .BUS_LOCK(BUS_LOCK),
      .GNT(GNT), .DONE(DONE), .ERR(ERR)
   );

   // {req, sel[1:0], lock, gnt[3:0], done[3:0], err}
   assign obs = {BUS_REQ, BUS_SEL, BUS_LOCK, GNT, DONE, ERR};

   always #5 CLK = ~CLK;

   task automatic drive(input logic [7:0] v);
      {EXH_REQ, WR_REQ, RD_REQ, OPD_REQ, RMW_LOCK, BUS_ACK, BUS_DONE, BUS_ERR} = v;
   endtask

   task automatic step(input logic [7:0] v);
      @(negedge CLK);
      drive(v);
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [12:0] exp, input logic [12:0] mask);
      checks++;
      if ((obs & mask) !== (exp & mask)) begin
         errors++;
         $display("FAIL %s: got %b expected %b (req_sel_lock_gnt_done_err)", name, obs & mask, exp & mask);
      end
   endtask

   task automatic do_xfer(input string name, input logic [7:0] req, input logic [7:0] late,
                          input logic [3:0] exp_gnt, input logic [1:0] exp_sel,
                          input logic lock_g, input logic err, input logic lock_after);
      step(req);
      chk({name, " grant"}, {1'b1, exp_sel, lock_g, exp_gnt, 4'b0000, 1'b0}, FULL);
      step(req | late | I_ACK);
      chk({name, " ack"}, {1'b0, exp_sel, lock_g, exp_gnt, 4'b0000, 1'b0}, FULL);
      step(req | late | I_DONE | (err ? I_ERR : 8'd0));
      chk({name, " done"}, {1'b0, exp_sel, lock_after, 4'b0000, exp_gnt, err}, NO_SEL);
   endtask

   initial begin
      // Priority run with two-cycle ACK/DONE, then spurious handshakes.
      vecs[0]  = '{8'b1111_0000, 13'b1_11_0_1000_0000_0};
      vecs[1]  = '{8'b1111_0000, 13'b1_11_0_1000_0000_0};
      vecs[2]  = '{8'b1111_0100, 13'b0_11_0_1000_0000_0};
      vecs[3]  = '{8'b1111_0000, 13'b0_11_0_1000_0000_0};
      vecs[4]  = '{8'b1111_0010, 13'b0_11_0_0000_1000_0};
      vecs[5]  = '{8'b0111_0000, 13'b1_10_0_0100_0000_0};
      vecs[6]  = '{8'b0111_0000, 13'b1_10_0_0100_0000_0};
      vecs[7]  = '{8'b0111_0100, 13'b0_10_0_0100_0000_0};
      vecs[8]  = '{8'b0111_0000, 13'b0_10_0_0100_0000_0};
      vecs[9]  = '{8'b0111_0010, 13'b0_10_0_0000_0100_0};
      vecs[10] = '{8'b0011_0000, 13'b1_01_0_0010_0000_0};
      vecs[11] = '{8'b0011_0000, 13'b1_01_0_0010_0000_0};
      vecs[12] = '{8'b0011_0100, 13'b0_01_0_0010_0000_0};
      vecs[13] = '{8'b0011_0000, 13'b0_01_0_0010_0000_0};
      vecs[14] = '{8'b0011_0010, 13'b0_01_0_0000_0010_0};
      vecs[15] = '{8'b0001_0000, 13'b1_00_0_0001_0000_0};
      vecs[16] = '{8'b0001_0000, 13'b1_00_0_0001_0000_0};
      vecs[17] = '{8'b0001_0100, 13'b0_00_0_0001_0000_0};
      vecs[18] = '{8'b0001_0000, 13'b0_00_0_0001_0000_0};
      vecs[19] = '{8'b0001_0010, 13'b0_00_0_0000_0001_0};
      vecs[20] = '{8'b0000_0000, 13'b0_00_0_0000_0000_0};
      vecs[21] = '{8'b0000_0011, 13'b0_00_0_0000_0000_0};
      vecs[22] = '{8'b0001_0000, 13'b1_00_0_0001_0000_0};
      vecs[23] = '{8'b0001_0100, 13'b0_00_0_0001_0000_0};
      vecs[24] = '{8'b0001_0100, 13'b0_00_0_0001_0000_0};
      vecs[25] = '{8'b0001_0010, 13'b0_00_0_0000_0001_0};
      vecs[26] = '{8'b0000_0000, 13'b0_00_0_0000_0000_0};

      drive(8'd0);
      repeat (2) @(posedge CLK);
      #1;
      chk("reset_state", 13'd0, FULL);
      @(negedge CLK);
      RESET_n = 1'b1;

      // Reset in the middle of a locked RD transfer.
      step(I_RD | I_RMW);
      chk("rst_grant", 13'b1_01_1_0010_0000_0, FULL);
      step(I_RD | I_RMW | I_ACK);
      chk("rst_xfer", 13'b0_01_1_0010_0000_0, FULL);
      #2;
      RESET_n = 1'b0;
      #1;
      chk("rst_async", 13'd0, FULL);
      step(I_DONE);
      chk("rst_held", 13'd0, FULL);
      @(negedge CLK);
      RESET_n = 1'b1;
      step(I_DONE);
      chk("rst_no_done", 13'd0, FULL);
      step(8'd0);
      chk("rst_idle", 13'd0, FULL);

      for (int i = 0; i < 27; i++) begin
         step(vecs[i].stim);
         chk($sformatf("vec%0d", i), vecs[i].exp, (vecs[i].exp[8:5] == 4'b0000) ? NO_SEL : FULL);
      end

      // RD and OPD held: every fifth grant is the forced OPD.
      for (int i = 0; i < 10; i++) begin
         if ((i % 5) == 4) begin
            do_xfer($sformatf("starve%0d_opd", i), I_RD | I_OPD, 8'd0, 4'b0001, 2'd0, 1'b0, 1'b0, 1'b0);
         end else begin
            do_xfer($sformatf("starve%0d_rd", i), I_RD | I_OPD, 8'd0, 4'b0010, 2'd1, 1'b0, 1'b0, 1'b0);
         end
      end

      // Locked RMW: EXH must wait for the locked WR to finish.
      do_xfer("rmw_rd", I_RD | I_RMW, 8'd0, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1);
      step(I_EXH);
      chk("rmw_exh_blocked1", 13'b0_00_1_0000_0000_0, NO_SEL);
      step(I_EXH);
      chk("rmw_exh_blocked2", 13'b0_00_1_0000_0000_0, NO_SEL);
      do_xfer("rmw_wr", I_EXH | I_WR, 8'd0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
      do_xfer("rmw_exh", I_EXH, 8'd0, 4'b1000, 2'd3, 1'b0, 1'b0, 1'b0);

      // Bus error on a locked RD releases the lock; pending WR goes normally.
      do_xfer("err_rd", I_RD | I_RMW, I_WR, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0);
      do_xfer("err_wr", I_WR, 8'd0, 4'b0100, 2'd2, 1'b0, 1'b0, 1'b0);
      step(8'd0);
      chk("final_idle", 13'd0, NO_SEL);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
